// File: rtl/cam_fill_ctrl.sv
// Lookup/fill controller in front of a tag CAM: serves hits from the CAM, fills misses
// from backing memory into a round-robin victim slot, and runs a sequential full invalidate.
module cam_fill_ctrl #(
    parameter int  WORDS  = 8,
    parameter int  BITS   = 8,
    parameter int  TAG_SZ = 8,
    parameter int  CNT_W  = 16,
    localparam int AW     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    input  logic [TAG_SZ-1:0] req_tag,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BITS-1:0]   rsp_data,
    output logic              rsp_hit,
    input  logic              flush,
    output logic              busy,
    output logic              cam_read,
    output logic [TAG_SZ-1:0] cam_check_tag,
    input  logic              cam_found_it,
    input  logic [BITS-1:0]   cam_data,
    output logic              cam_write_,
    output logic [AW-1:0]     cam_w_addr,
    output logic [BITS-1:0]   cam_wdata,
    output logic [TAG_SZ-1:0] cam_new_tag,
    output logic              cam_new_valid,
    output logic              mem_req,
    output logic [TAG_SZ-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [BITS-1:0]   mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MISS_REQ = 3'd2,
        S_FILL     = 3'd3,
        S_RESP     = 3'd4,
        S_FLUSH    = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [TAG_SZ-1:0]  r_tag_q;
    logic [BITS-1:0]    r_data_q;
    logic               r_hit_q;
    logic [AW-1:0]      r_victim;
    logic [AW-1:0]      r_flush_idx;
    logic               r_flush_pend;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;
    logic               w_accept;
    logic               w_enter_flush;
    logic               w_flush_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_accept      = (r_state == S_IDLE) && !r_flush_pend && req_valid;
    assign w_enter_flush = (r_state == S_IDLE) && r_flush_pend;
    assign w_flush_last  = (r_state == S_FLUSH) && (r_flush_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a pending flush wins over a new request in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_flush_pend) begin
                    w_next_state = S_FLUSH;
                end else if (req_valid) begin
                    w_next_state = S_LOOKUP;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (cam_found_it) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (mem_ack) begin
                    w_next_state = S_FILL;
                end else begin
                    w_next_state = S_MISS_REQ;
                end
            end
            S_FILL:  w_next_state = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            S_FLUSH: begin
                if (w_flush_last) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FLUSH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request tag and response data capture
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_tag_q  <= {TAG_SZ{1'b0}};
            r_data_q <= {BITS{1'b0}};
            r_hit_q  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag_q <= req_tag;
            end
            if ((r_state == S_LOOKUP) && cam_found_it) begin
                r_data_q <= cam_data;
                r_hit_q  <= 1'b1;
            end else if ((r_state == S_MISS_REQ) && mem_ack) begin
                r_data_q <= mem_rdata;
                r_hit_q  <= 1'b0;
            end
        end
    end

    // Saturating hit/miss statistics, decided at the end of LOOKUP
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_hit_cnt  <= {CNT_W{1'b0}};
            r_miss_cnt <= {CNT_W{1'b0}};
        end else if (r_state == S_LOOKUP) begin
            if (cam_found_it) begin
                r_hit_cnt <= sat_inc(r_hit_cnt);
            end else begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    // Round-robin victim pointer and flush sweep index
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_victim    <= {AW{1'b0}};
            r_flush_idx <= {AW{1'b0}};
        end else begin
            if (r_state == S_FILL) begin
                r_victim <= (r_victim == LAST_IDX) ? {AW{1'b0}} : r_victim + AW'(1);
            end else if (w_flush_last) begin
                r_victim <= {AW{1'b0}};
            end
            if (r_state == S_FLUSH) begin
                r_flush_idx <= w_flush_last ? {AW{1'b0}} : r_flush_idx + AW'(1);
            end
        end
    end

    // Flush request latch; a new pulse beats the clear so a flush during FLUSH repeats it
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_flush_pend <= 1'b0;
        end else if (flush) begin
            r_flush_pend <= 1'b1;
        end else if (w_enter_flush) begin
            r_flush_pend <= 1'b0;
        end
    end

    // Output decode from registered state only
    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = {BITS{1'b0}};
        rsp_hit       = 1'b0;
        cam_read      = 1'b0;
        cam_check_tag = {TAG_SZ{1'b0}};
        cam_write_    = 1'b1;
        cam_w_addr    = {AW{1'b0}};
        cam_wdata     = {BITS{1'b0}};
        cam_new_tag   = {TAG_SZ{1'b0}};
        cam_new_valid = 1'b0;
        mem_req       = 1'b0;
        mem_addr      = {TAG_SZ{1'b0}};
        busy          = (r_state != S_IDLE) || r_flush_pend;
        case (r_state)
            S_IDLE:   req_ready = !r_flush_pend;
            S_LOOKUP: begin
                cam_read      = 1'b1;
                cam_check_tag = r_tag_q;
            end
            S_MISS_REQ: begin
                mem_req  = 1'b1;
                mem_addr = r_tag_q;
            end
            S_FILL: begin
                cam_write_    = 1'b0;
                cam_w_addr    = r_victim;
                cam_wdata     = r_data_q;
                cam_new_tag   = r_tag_q;
                cam_new_valid = 1'b1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = r_data_q;
                rsp_hit   = r_hit_q;
            end
            S_FLUSH: begin
                cam_write_ = 1'b0;
                cam_w_addr = r_flush_idx;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule
